// File: rtl/keypad_scan_controller_if.sv
// Keypad controller signal bundle: pin side (scan_en/col_in/row_out) and key-consumer side.
// No latency of its own. No backpressure: key_valid is a fire-and-forget strobe.
interface keypad_scan_controller_if;
    logic       scan_en;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        output scan_en, col_in,
        input  row_out, key_code, key_valid, key_held
    );

    modport slave (
        input  scan_en, col_in,
        output row_out, key_code, key_valid, key_held
    );
endinterface

// File: rtl/keypad_scan_controller.sv
// 4x4 keypad scanner: one-hot active-low row drive, debounced press/release, hex code + 1-cycle strobe.
// Latency: 2-cycle column sync, then DEBOUNCE_TICKS scan ticks from first valid sample to key_valid.
// No backpressure: the consumer must take key_valid when it fires; key_code holds until the next press.
module keypad_scan_controller #(
    parameter int SCAN_DIV       = 27000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    keypad_scan_controller_if.slave  kif
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   div_cnt;
    logic [CW-1:0]   deb_cnt;
    logic [CW-1:0]   rel_cnt;
    logic [1:0]      row_idx;
    logic [1:0]      cand_col;
    logic [3:0]      col_m;
    logic [3:0]      col_s;
    logic [3:0]      key_code_r;
    logic            key_valid_r;

    logic            tick;
    logic            col_valid;
    logic [1:0]      col_idx;
    logic            same_col;
    logic            released;
    logic            deb_done;
    logic            rel_done;
    logic            accept;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Only a single low column is a key; ghosting/multi-press patterns read as no key.
    always_comb begin
        col_valid = 1'b1;
        col_idx   = 2'd0;
        case (col_s)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_valid = 1'b0;
        endcase
    end

    assign tick     = (state != IDLE) && (div_cnt == DW'(SCAN_DIV - 1));
    assign same_col = col_valid && (col_idx == cand_col);
    assign released = col_s[cand_col];
    assign deb_done = (deb_cnt == CW'(DEBOUNCE_TICKS - 1));
    assign rel_done = (rel_cnt == CW'(DEBOUNCE_TICKS - 1));
    assign accept   = kif.scan_en && (state == DEBOUNCE) && tick && same_col && deb_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!kif.scan_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:     state_nxt = SCAN;
                SCAN:     if (tick && col_valid) state_nxt = DEBOUNCE;
                DEBOUNCE: if (tick) state_nxt = same_col ? (deb_done ? PRESSED : DEBOUNCE) : SCAN;
                PRESSED:  if (tick && released) state_nxt = RELEASE;
                RELEASE:  if (tick) state_nxt = released ? (rel_done ? SCAN : RELEASE) : PRESSED;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        kif.row_out  = 4'b1111;
        kif.key_held = 1'b0;
        case (state)
            IDLE:             kif.row_out = 4'b1111;
            PRESSED, RELEASE: begin
                kif.row_out  = ~(4'b0001 << row_idx);
                kif.key_held = 1'b1;
            end
            default:          kif.row_out = ~(4'b0001 << row_idx);
        endcase
    end

    assign kif.key_code  = key_code_r;
    assign kif.key_valid = key_valid_r;

    // Row index and counters only move on tick, so a row change lands the cycle after the sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_m       <= 4'b1111;
            col_s       <= 4'b1111;
            div_cnt     <= '0;
            deb_cnt     <= '0;
            rel_cnt     <= '0;
            row_idx     <= 2'd0;
            cand_col    <= 2'd0;
            key_code_r  <= 4'h0;
            key_valid_r <= 1'b0;
        end else begin
            col_m       <= kif.col_in;
            col_s       <= col_m;
            key_valid_r <= accept;
            if (accept) begin
                key_code_r <= key_map(row_idx, cand_col);
            end
            if (!kif.scan_en || state == IDLE) begin
                div_cnt <= '0;
                deb_cnt <= '0;
                rel_cnt <= '0;
                row_idx <= 2'd0;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + DW'(1);
                if (tick) begin
                    case (state)
                        SCAN: begin
                            if (col_valid) begin
                                cand_col <= col_idx;
                                deb_cnt  <= CW'(1);
                            end else begin
                                row_idx <= row_idx + 2'd1;
                            end
                        end
                        DEBOUNCE: begin
                            if (same_col) begin
                                deb_cnt <= deb_done ? '0 : deb_cnt + CW'(1);
                            end else begin
                                deb_cnt <= '0;
                                row_idx <= row_idx + 2'd1;
                            end
                        end
                        PRESSED: begin
                            if (released) rel_cnt <= CW'(1);
                        end
                        RELEASE: begin
                            if (!released) begin
                                rel_cnt <= '0;
                            end else if (rel_done) begin
                                rel_cnt <= '0;
                                row_idx <= row_idx + 2'd1;
                            end else begin
                                rel_cnt <= rel_cnt + CW'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Bench for keypad_scan_controller: a contact-level keypad model drives col_in from row_out,
// and key codes / strobe counts are checked against the keypad map and timing rules.
module tb_keypad_scan_controller;

    localparam int SD = 4;
    localparam int DT = 3;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    keypad_scan_controller_if kif();

    keypad_scan_controller #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_TICKS (DT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Contact model: pressed[r][c] = 1 means key at row r, column c is closed.
    logic [3:0] pressed [4];
    logic [3:0] col_drive;
    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};
    logic [3:0] model_code = 4'h0;

    always_comb begin
        col_drive = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (kif.row_out[r] == 1'b0) col_drive = col_drive & ~pressed[r];
        end
        kif.col_in = col_drive;
    end

    // Strobe monitor: counts key_valid pulses, checks pulse width and that key_code moves only with key_valid.
    int         vld_count = 0;
    logic [3:0] last_code = 4'h0;
    logic       prev_vld  = 1'b0;
    logic [3:0] prev_code = 4'h0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_vld  = 1'b0;
                prev_code = kif.key_code;
            end else begin
                n_tests++;
                if (kif.key_valid && prev_vld) begin
                    n_fail++;
                    $display("FAIL valid_width: key_valid=1 on consecutive cycles, required single-cycle pulse");
                end
                n_tests++;
                if (!kif.key_valid && kif.key_code !== prev_code) begin
                    n_fail++;
                    $display("FAIL code_stable: key_code=%h without key_valid, required %h", kif.key_code, prev_code);
                end
                if (kif.key_valid) begin
                    vld_count++;
                    last_code = kif.key_code;
                end
                prev_vld  = kif.key_valid;
                prev_code = kif.key_code;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pulse(input int v0, input string name);
        int t = 0;
        while (vld_count == v0 && t < 200) begin
            cyc(1);
            t++;
        end
        n_tests++;
        if (vld_count == v0) begin
            n_fail++;
            $display("FAIL %s_timeout: no key_valid within 200 cycles, required one", name);
        end
    endtask

    task automatic wait_unheld(input string name);
        int t = 0;
        while (kif.key_held !== 1'b0 && t < 60) begin
            cyc(1);
            t++;
        end
        n_tests++;
        if (kif.key_held !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release: key_held=%b after 60 cycles, required 0", name, kif.key_held);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        kif.scan_en = 1'b0;
        cyc(2);
        n_tests++;
        if (kif.row_out !== 4'b1111) begin n_fail++; $display("FAIL reset_row: got %b, required 1111", kif.row_out); end
        n_tests++;
        if (kif.key_code !== 4'h0) begin n_fail++; $display("FAIL reset_code: got %h, required 0", kif.key_code); end
        n_tests++;
        if (kif.key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", kif.key_valid); end
        n_tests++;
        if (kif.key_held !== 1'b0) begin n_fail++; $display("FAIL reset_held: got %b, required 0", kif.key_held); end
        rst = 1'b0;
        cyc(3);
        n_tests++;
        if (kif.row_out !== 4'b1111) begin n_fail++; $display("FAIL idle_row: got %b, required 1111", kif.row_out); end
    endtask

    task automatic test_idle_scan;
        int         v0 = vld_count;
        logic [3:0] exp;
        kif.scan_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            exp = 4'b1111 ^ (4'b0001 << ((i / SD) % 4));
            n_tests++;
            if (kif.row_out !== exp) begin
                n_fail++;
                $display("FAIL scan_row[%0d]: got %b, required %b", i, kif.row_out, exp);
            end
        end
        n_tests++;
        if (vld_count != v0) begin n_fail++; $display("FAIL scan_no_key: %0d pulses, required 0", vld_count - v0); end
    endtask

    task automatic press_and_check(input int r, input int c, input string name);
        int         v0  = vld_count;
        logic [3:0] exp = keymap[r*4 + c];
        logic [3:0] r0;
        int         t;
        pressed[r][c] = 1'b1;
        wait_pulse(v0, name);
        cyc($urandom_range(5, 30));
        n_tests++;
        if (vld_count != v0 + 1) begin n_fail++; $display("FAIL %s_count: %0d pulses, required 1", name, vld_count - v0); end
        n_tests++;
        if (kif.key_code !== exp) begin n_fail++; $display("FAIL %s_code: got %h, required %h", name, kif.key_code, exp); end
        n_tests++;
        if (kif.key_held !== 1'b1) begin n_fail++; $display("FAIL %s_held: got %b, required 1", name, kif.key_held); end
        model_code = exp;
        pressed[r][c] = 1'b0;
        cyc(6);
        n_tests++;
        if (kif.key_held !== 1'b1) begin n_fail++; $display("FAIL %s_early_release: key_held=%b, required 1", name, kif.key_held); end
        wait_unheld(name);
        r0 = kif.row_out;
        t = 0;
        while (kif.row_out === r0 && t < 2*SD + 2) begin
            cyc(1);
            t++;
        end
        n_tests++;
        if (kif.row_out === r0) begin n_fail++; $display("FAIL %s_resume: row_out stuck at %b, required advancing", name, r0); end
        n_tests++;
        if (vld_count != v0 + 1) begin n_fail++; $display("FAIL %s_extra: %0d pulses, required 1", name, vld_count - v0); end
    endtask

    task automatic test_bounce(input int r, input int c, input string name);
        int         v0  = vld_count;
        logic [3:0] exp = keymap[r*4 + c];
        int         nb  = $urandom_range(1, 3);
        for (int k = 0; k < nb; k++) begin
            pressed[r][c] = 1'b1;
            cyc(SD);
            pressed[r][c] = 1'b0;
            cyc(SD);
        end
        n_tests++;
        if (vld_count != v0) begin n_fail++; $display("FAIL %s_bounce: %0d pulses during bounce, required 0", name, vld_count - v0); end
        pressed[r][c] = 1'b1;
        cyc(8);
        n_tests++;
        if (vld_count != v0) begin n_fail++; $display("FAIL %s_early: %0d pulses before 3 stable ticks, required 0", name, vld_count - v0); end
        wait_pulse(v0, name);
        cyc(10);
        n_tests++;
        if (vld_count != v0 + 1 || last_code !== exp) begin
            n_fail++;
            $display("FAIL %s_code: %0d pulses code %h, required 1 pulse code %h", name, vld_count - v0, last_code, exp);
        end
        model_code = exp;
        pressed[r][c] = 1'b0;
        wait_unheld(name);
    endtask

    task automatic test_rollover;
        int v0 = vld_count;
        pressed[0][3] = 1'b1;
        wait_pulse(v0, "roll");
        model_code = 4'hA;
        pressed[1][2] = 1'b1;
        cyc(20);
        pressed[0][3] = 1'b0;
        cyc(SD);
        pressed[0][3] = 1'b1;
        cyc(40);
        n_tests++;
        if (vld_count != v0 + 1) begin n_fail++; $display("FAIL roll_count: %0d pulses, required 1", vld_count - v0); end
        n_tests++;
        if (kif.key_code !== 4'hA) begin n_fail++; $display("FAIL roll_code: got %h, required a", kif.key_code); end
        n_tests++;
        if (kif.key_held !== 1'b1) begin n_fail++; $display("FAIL roll_held: got %b, required 1", kif.key_held); end
        pressed[0][3] = 1'b0;
        pressed[1][2] = 1'b0;
        wait_unheld("roll");
        cyc(10);
        n_tests++;
        if (vld_count != v0 + 1) begin n_fail++; $display("FAIL roll_after: %0d pulses, required 1", vld_count - v0); end
    endtask

    task automatic test_multi_col;
        int         v0   = vld_count;
        logic [3:0] seen = 4'h0;
        pressed[0] = 4'b0011;
        for (int i = 0; i < 80; i++) begin
            cyc(1);
            if (kif.row_out !== 4'b1111) seen = seen | ~kif.row_out;
        end
        n_tests++;
        if (vld_count != v0) begin n_fail++; $display("FAIL multi_valid: %0d pulses, required 0", vld_count - v0); end
        n_tests++;
        if (seen !== 4'hF) begin n_fail++; $display("FAIL multi_rows: rows seen %b, required 1111", seen); end
        pressed[0] = 4'b0000;
    endtask

    task automatic test_scan_en_drop;
        int         r   = $urandom_range(0, 3);
        int         c   = $urandom_range(0, 3);
        int         v0  = vld_count;
        logic [3:0] exp = 4'b1111 ^ (4'b0001 << r);
        int         t   = 0;
        kif.scan_en = 1'b0;
        cyc(2);
        pressed[r][c] = 1'b1;
        kif.scan_en = 1'b1;
        while (kif.row_out !== exp && t < 40) begin
            cyc(1);
            t++;
        end
        n_tests++;
        if (kif.row_out !== exp) begin n_fail++; $display("FAIL drop_find: row_out %b, required %b", kif.row_out, exp); end
        cyc(6);
        kif.scan_en = 1'b0;
        cyc(1);
        n_tests++;
        if (kif.row_out !== 4'b1111) begin n_fail++; $display("FAIL drop_row: got %b, required 1111", kif.row_out); end
        n_tests++;
        if (kif.key_held !== 1'b0) begin n_fail++; $display("FAIL drop_held: got %b, required 0", kif.key_held); end
        cyc(30);
        n_tests++;
        if (vld_count != v0) begin n_fail++; $display("FAIL drop_valid: %0d pulses, required 0", vld_count - v0); end
        n_tests++;
        if (kif.key_code !== model_code) begin n_fail++; $display("FAIL drop_code: got %h, required %h", kif.key_code, model_code); end
        pressed[r][c] = 1'b0;
        kif.scan_en = 1'b1;
        cyc(2);
    endtask

    task automatic test_rst_pressed;
        int r = $urandom_range(0, 3);
        int c = $urandom_range(0, 3);
        int t = 0;
        pressed[r][c] = 1'b1;
        while (kif.key_valid !== 1'b1 && t < 200) begin
            cyc(1);
            t++;
        end
        n_tests++;
        if (kif.key_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_press: key_valid never seen, required pulse");
        end
        rst = 1'b1;
        #1;
        model_code = 4'h0;
        n_tests++;
        if (kif.row_out !== 4'b1111) begin n_fail++; $display("FAIL rst_row: got %b, required 1111", kif.row_out); end
        n_tests++;
        if (kif.key_code !== model_code) begin n_fail++; $display("FAIL rst_code: got %h, required %h", kif.key_code, model_code); end
        n_tests++;
        if (kif.key_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", kif.key_valid); end
        n_tests++;
        if (kif.key_held !== 1'b0) begin n_fail++; $display("FAIL rst_held: got %b, required 0", kif.key_held); end
        cyc(1);
        pressed[r][c] = 1'b0;
        rst = 1'b0;
        cyc(2);
    endtask

    initial begin
        rst = 1'b1;
        kif.scan_en = 1'b0;
        for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;
        test_reset();
        test_idle_scan();
        press_and_check(1, 1, "key5");
        test_bounce(3, 2, "hash");
        for (int i = 0; i < 5; i++) begin
            press_and_check($urandom_range(0, 3), $urandom_range(0, 3), "rand");
        end
        for (int i = 0; i < 2; i++) begin
            test_bounce($urandom_range(0, 3), $urandom_range(0, 3), "rbounce");
        end
        test_rollover();
        test_multi_col();
        test_scan_en_drop();
        test_rst_pressed();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
